// File: rtl/score_display.sv
// BCD score counter with a time-multiplexed 7-segment scan driver.
// Optional build macro: SCORE_LZ_BLANK_EN (blank leading-zero digits).
module score_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 10000,
  parameter int unsigned SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   score,
  output logic                  at_max,
  output logic [DIGITS-1:0]     select,
  output logic [6:0]            seg
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam bit          SAT   = (SATURATE != 0);

  logic                   inc_q;
  logic                   inc_pulse;
  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0][3:0] digits_inc;
  logic [DIV_W-1:0]       div;
  logic [IDX_W-1:0]       idx;
  logic                   tick;
  logic                   blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  assign digits    = score;
  assign inc_pulse = inc & ~inc_q;
  assign tick      = (div == DIV_W'(SCAN_DIV - 1));

  // Ripple BCD +1; the final carry is set only when every digit is 9.
  always_comb begin
    logic carry;
    carry      = 1'b1;
    digits_inc = digits;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (carry) begin
        digits_inc[k] = (digits[k] == 4'd9) ? 4'd0 : 4'(digits[k] + 4'd1);
      end
      carry = carry & (digits[k] == 4'd9);
    end
    at_max = carry;
  end

`ifdef SCORE_LZ_BLANK_EN
  logic [DIGITS-1:0] lz;

  // A digit is a leading zero when it and every higher digit are zero.
  always_comb begin
    logic higher_zero;
    higher_zero = 1'b1;
    lz          = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      higher_zero = higher_zero & (digits[k] == 4'd0);
      lz[k]       = higher_zero & (k != 0);
    end
  end

  assign blank = lz[idx];
`else
  assign blank = 1'b0;
`endif

  // Edge register and score update; clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_q <= 1'b0;
      score <= '0;
    end else begin
      inc_q <= inc;
      if (clr) begin
        score <= '0;
      end else if (inc_pulse && !(SAT && at_max)) begin
        score <= digits_inc;
      end
    end
  end

  // Scan divider, digit index and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= '0;
      idx    <= '0;
      select <= '1;
      seg    <= 7'h7F;
    end else begin
      div <= tick ? '0 : DIV_W'(div + DIV_W'(1));
      if (tick) begin
        idx    <= (idx == IDX_W'(DIGITS - 1)) ? '0 : IDX_W'(idx + IDX_W'(1));
        select <= ~(DIGITS'(1) << idx);
        seg    <= blank ? 7'h7F : decode(digits[idx]);
      end
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: wrap and saturate instances share stimulus
// and are checked every cycle against a decimal reference model.
module tb_score_display;

  localparam int unsigned D  = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned MAXV = 9999;

  logic        clk = 1'b0;
  logic        rst, inc, clr;
  logic [15:0] score_w, score_s;
  logic        at_max_w, at_max_s;
  logic [3:0]  sel_w, sel_s;
  logic [6:0]  seg_w, seg_s;

  score_display #(.DIGITS(D), .SCAN_DIV(SD), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .score(score_w), .at_max(at_max_w), .select(sel_w), .seg(seg_w));

  score_display #(.DIGITS(D), .SCAN_DIV(SD), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .inc(inc), .clr(clr),
    .score(score_s), .at_max(at_max_s), .select(sel_s), .seg(seg_s));

  always #5 clk = ~clk;

  typedef struct {
    int unsigned sw;
    int unsigned ss;
    logic [3:0]  selw;
    logic [3:0]  sels;
    logic [6:0]  segw;
    logic [6:0]  segs;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model state: decimal scores, previous inc level, cycles since reset.
  int unsigned cnt_w, cnt_s, n;
  bit          prev;
  logic [3:0]  selw_m, sels_m;
  logic [6:0]  segw_m, segs_m;
  logic [6:0]  segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic int unsigned pow10(input int unsigned k);
    int unsigned p = 1;
    for (int i = 0; i < int'(k); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0] r = '0;
    for (int k = 0; k < int'(D); k++)
      r = r | (32'((v / pow10(k)) % 10) << (4 * k));
    return r;
  endfunction

  function automatic logic [6:0] seg_of(input int unsigned v, input int unsigned k);
    int unsigned p = pow10(k);
`ifdef SCORE_LZ_BLANK_EN
    if (k > 0 && v < p) return 7'h7F;
`endif
    return segtab[(v / p) % 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push the model's post-edge expectation.
  task automatic step(input logic r, input logic i, input logic c);
    exp_t        e;
    int unsigned k;
    logic [3:0]  one = 4'b0001;
    @(negedge clk);
    rst = r; inc = i; clr = c;
    if (r) begin
      cnt_w = 0; cnt_s = 0; prev = 1'b0; n = 0;
      selw_m = 4'hF; sels_m = 4'hF; segw_m = 7'h7F; segs_m = 7'h7F;
    end else begin
      if (n % SD == SD - 1) begin
        k      = (n / SD) % D;
        selw_m = ~(one << k);
        sels_m = ~(one << k);
        segw_m = seg_of(cnt_w, k);
        segs_m = seg_of(cnt_s, k);
      end
      n++;
      if (c) begin
        cnt_w = 0; cnt_s = 0;
      end else if (i && !prev) begin
        cnt_w = (cnt_w == MAXV) ? 0 : cnt_w + 1;
        cnt_s = (cnt_s == MAXV) ? cnt_s : cnt_s + 1;
      end
      prev = i;
    end
    e.sw = cnt_w; e.ss = cnt_s;
    e.selw = selw_m; e.sels = sels_m; e.segw = segw_m; e.segs = segs_m;
    q.push_back(e);
  endtask

  task automatic pulse();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) step(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs settle after each edge; compare against the queued expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("score_wrap", 32'(score_w), to_bcd(e.sw));
      check("score_sat",  32'(score_s), to_bcd(e.ss));
      check("at_max_wrap", 32'(at_max_w), 32'(e.sw == MAXV));
      check("at_max_sat",  32'(at_max_s), 32'(e.ss == MAXV));
      check("select_wrap", 32'(sel_w), 32'(e.selw));
      check("select_sat",  32'(sel_s), 32'(e.sels));
      check("seg_wrap", 32'(seg_w), 32'(e.segw));
      check("seg_sat",  32'(seg_s), 32'(e.segs));
    end
  end

  initial begin
    rst = 1'b1; inc = 1'b0; clr = 1'b0;
    repeat (3) step(1'b1, 1'b0, 1'b0);
    idle(18);
    // Held level counts once, then five single pulses.
    repeat (10) step(1'b0, 1'b1, 1'b0);
    repeat (5) pulse();
    idle(4);
    // Carry chain through 0099.
    step(1'b0, 1'b0, 1'b1);
    repeat (99) pulse();
    pulse();
    pulse();
    idle(4);
    // Overflow at 9999.
    step(1'b0, 1'b0, 1'b1);
    repeat (MAXV) pulse();
    idle(4);
    pulse();
    idle(20);
    // Clear collides with an increment edge.
    step(1'b0, 1'b0, 1'b1);
    repeat (37) pulse();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    idle(4);
    // Decode sweep of 1234, then 0005 for leading-zero behaviour.
    step(1'b0, 1'b0, 1'b1);
    repeat (1234) pulse();
    idle(20);
    step(1'b0, 1'b0, 1'b1);
    repeat (5) pulse();
    idle(20);
    // Random traffic with a reset in the middle of a scan frame.
    for (int i = 0; i < 400; i++) begin
      if (i == 201 || i == 202)
        step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      else
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end
    idle(2);
    @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
